// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART constants and state encoding for the receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - Receive-FIFO write port and status pulses of the UART receiver.
interface uart_rx_if;

  logic [7:0] fifodata;
  logic       fifowe;
  logic       fifofull;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output fifodata, fifowe, busy, frame_err, overrun, parity_err,
    input  fifofull
  );

  modport slave (
    input  fifodata, fifowe, busy, frame_err, overrun, parity_err,
    output fifofull
  );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - Free-running divider giving one 16x-oversample tick every CLK_DIV clocks.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling 8N1 UART receiver writing bytes into a FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master fifo
);

  localparam logic [3:0] T_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] T_LAST = 4'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   tick;
  logic                   armed;
  uart_state_e            state;
  logic [3:0]             tcnt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic [7:0]             data_q;
  logic                   we_q;
  logic                   fe_q;
  logic                   ov_q;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q;
  logic                   pe_q;
`endif

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

  // armed is cleared by a framing error so a stuck-low line cannot start a new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      armed  <= 1'b0;
      data_q <= '0;
      we_q   <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
      pe_q   <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (tick && armed && !rx_s) begin
            state <= START;
            tcnt  <= '0;
          end
        end
        START: if (tick) begin
          if (tcnt == T_MID) begin
            tcnt   <= '0;
            bitcnt <= '0;
            state  <= rx_s ? IDLE : DATA;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        DATA: if (tick) begin
          if (tcnt == T_LAST) begin
            tcnt   <= '0;
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bitcnt == 3'd7) state <= PARITY;
`else
            if (bitcnt == 3'd7) state <= STOP;
`endif
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (tcnt == T_LAST) begin
            tcnt   <= '0;
            perr_q <= ^{shreg, rx_s};
            state  <= STOP;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
`endif
        STOP: if (tick) begin
          if (tcnt == T_LAST) begin
            tcnt  <= '0;
            state <= IDLE;
            if (!rx_s) begin
              fe_q  <= 1'b1;
              armed <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            else if (perr_q) pe_q <= 1'b1;
`endif
            else if (fifo.fifofull) ov_q <= 1'b1;
            else begin
              we_q   <= 1'b1;
              data_q <= shreg;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo.fifodata  = data_q;
  assign fifo.fifowe    = we_q;
  assign fifo.busy      = (state != IDLE);
  assign fifo.frame_err = fe_q;
  assign fifo.overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign fifo.parity_err = pe_q;
`else
  assign fifo.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLK_DIV, 27, clk cycles per 16x-oversample tick (50 MHz / 115200 baud / 16).
REQ-002 SHALL have parameter: SYNC_STAGES, 2, number of rx synchronizer flops (minimum 2).
REQ-003 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: rx  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port: fifodata  output  8  received byte; valid while fifowe is high.
REQ-007 SHALL have port: fifowe  output  1  one-cycle write strobe into the receive FIFO.
REQ-008 SHALL have port: fifofull  input  1  FIFO full indication, sampled in the cycle a write would occur.
REQ-009 SHALL have port: busy  output  1  high while a frame is in progress (state not IDLE).
REQ-010 SHALL have port: frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse when a good byte is dropped because fifofull is high.
REQ-012 SHALL have port: parity_err  output  1  one-cycle pulse when the parity check fails; tied 0 without UART_RX_PARITY_EN.

Function
REQ-013 SHALL pass rx through SYNC_STAGES flops reset to 1; all decoding SHALL use the synchronized value only.
REQ-014 SHALL generate a tick every CLK_DIV clocks from a free-running divider; the divider SHALL wrap from CLK_DIV-1 to 0.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE->START on synchronized rx low at a tick; the tick counter SHALL clear to 0.
REQ-017 START SHALL re-sample rx at tick count 7 (mid-bit); if high, it SHALL return to IDLE with no outputs (false start); if low, it SHALL go to DATA.
REQ-018 DATA SHALL sample 8 bits LSB first, each 16 ticks after the previous sample, into a shift register.
REQ-019 STOP SHALL sample rx 16 ticks after the last data/parity sample, then return to IDLE in the next clock.
REQ-020 On stop=1, no parity error and fifofull=0, fifowe SHALL be high for exactly one clock, the clock after the stop sample, with fifodata equal to the byte.
REQ-021 On stop=1 and fifofull=1, the byte SHALL be dropped and overrun SHALL pulse instead of fifowe.
REQ-022 On stop=0, the byte SHALL be dropped and frame_err SHALL pulse; the FSM SHALL return to IDLE and SHALL only re-arm after rx is seen high.
REQ-023 When frame_err and overrun conditions coincide, only frame_err SHALL pulse.
REQ-024 fifodata SHALL hold the last written byte between strobes.

Reset
REQ-025 While reset is low: state IDLE, divider and counters 0, synchronizer flops 1, fifodata 8'h00, all other outputs 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no fifowe, frame_err, overrun or parity_err pulse.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA and sample one even-parity bit.
- Mismatch: byte dropped, parity_err pulses at the fifowe time slot.
- Priority on coincidence: frame_err over parity_err over overrun.
REQ-028 Without UART_RX_PARITY_EN, frames SHALL be 8N1 and parity_err SHALL be constant 0.

Structure
REQ-029 The state enum, the constant OVERSAMPLE=16 and the constant MID_SAMPLE=7 SHALL live in shared package uart_pkg, reused by the transmitter.
REQ-030 The tick divider SHALL be a sub-module, uart_baud_tick (params CLK_DIV; ports clk, reset, tick).

Verification (CLK_DIV=4, one bit = 64 clk)
REQ-031 Frame 0xA5, 8N1, fifofull=0 -> single fifowe with fifodata=8'hA5; no error pulses.
REQ-032 rx low for 20 clk, then high -> false start; busy returns low, no fifowe.
REQ-033 Frame 0x3C with stop bit driven 0 -> frame_err pulse only; next frame 0x55 received correctly after rx returns high.
REQ-034 Frame 0xFF with fifofull=1 -> overrun pulse, no fifowe; fifodata retains previous value.
REQ-035 reset pulled low at bit 4 of frame 0x81, then released -> all outputs 0, no strobes; the following frame 0x81 is received intact.
REQ-036 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse; with parity bit 1 -> fifowe with fifodata=8'h07.
